mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port 32-bit program/data memory between three requesters: instruction fetch
//  (port F, driven by the controller's fetch state), data load/store (port D) and the host/debug
//  loader (port H). Grants at most one access per cycle and returns read data one cycle later.
//  Keeps a saturating fetch-stall counter so stalls caused by contention are visible on the debug bus.
// PARAMETERS
//  AW          16  memory address width (matches controller pc / memaddr)
//  DW          32  memory data width
//  HOST_BURST  4   max consecutive H grants while F or D is waiting (1..15)
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  reset        in   1   asynchronous, active-low reset
//  f_req        in   1   fetch request (read only)
//  f_addr       in   AW  fetch address
//  f_gnt        out  1   fetch accepted this cycle
//  f_rvalid     out  1   fetch read data valid on rdata
//  d_req        in   1   data request
//  d_we         in   1   data write enable (1=write, 0=read)
//  d_addr       in   AW  data address
//  d_wdata      in   DW  data write value
//  d_gnt        out  1   data accepted this cycle
//  d_rvalid     out  1   data read data valid on rdata
//  h_req/h_we/h_addr/h_wdata/h_gnt/h_rvalid   as D, for host loader
//  rdata        out  DW  shared read-return bus (= mem_rdata)
//  mem_en       out  1   memory access strobe
//  mem_we       out  1   memory write enable
//  mem_addr     out  AW  memory address
//  mem_wdata    out  DW  memory write data
//  mem_rdata    in   DW  memory read data, valid cycle after mem_en&&!mem_we
//  stall_clr    in   1   synchronous clear of stall_cnt
//  stall_cnt    out  16  cycles f_req was high but f_gnt low, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (reset==0, any time): all gnt/rvalid/mem_en/mem_we low, mem_addr/mem_wdata 0, rr_last=F,
//   host_run=0, stall_cnt=0. Accesses in flight are dropped; no rvalid after reset release.
//  Handshake: requester holds req and its addr/we/wdata stable until gnt; gnt is combinational in
//   the same cycle; req may drop the cycle after gnt. gnt never asserts without req.
//  Command path combinational: mem_en = |gnt; mem_we/addr/wdata muxed from granted port; idle
//   cycles drive mem_we=0 and hold mem_addr/mem_wdata at 0.
//  Read latency 1: x_rvalid registered = x_gnt && !x_we of previous cycle; rdata = mem_rdata.
//   Writes produce no rvalid. Back-to-back grants to any ports allowed every cycle.
//  Arbitration (one winner per cycle):
//   - H wins if h_req and (host_run < HOST_BURST or neither f_req nor d_req).
//   - otherwise F/D round-robin: if both request, winner = port not in rr_last; a single
//     requester wins. rr_last updates only on F or D grant.
//   - host_run: +1 on H grant while F or D requesting (saturating at HOST_BURST), cleared on any
//     F/D grant or cycle with no h_req. When host_run==HOST_BURST and F/D pending, H is blocked
//     exactly until one F/D grant occurs.
//  stall_cnt: +1 each cycle f_req && !f_gnt; saturates; stall_clr has priority over increment.
//  Same-address write then read on consecutive grants: read returns new data (memory write-first).
//  No state machine beyond rr_last (1 bit), host_run (4 bits), rvalid pipe (3 bits), stall_cnt.
// TESTING
//  1. F only, f_addr=0..7 every cycle -> f_gnt every cycle, f_rvalid 1 cycle later, rdata=mem[addr].
//  2. F and D read continuously -> grants alternate F,D,F,D starting with D after reset; stall_cnt
//     increments every other cycle.
//  3. H,F,D all requesting, HOST_BURST=4 -> H,H,H,H, then one F/D grant, then H resumes; F and D
//     each granted within 2*(HOST_BURST+1) cycles.
//  4. D write 0xDEADBEEF @0x0010, next cycle F read @0x0010 -> no d_rvalid; f_rvalid with rdata
//     0xDEADBEEF.
//  5. Reset asserted the cycle after an F grant -> f_rvalid stays 0, all outputs 0 during reset,
//     first grant after release follows rr_last=F rule.
//  6. F stalled 70000 cycles by H-only... with HOST_BURST limit off-loaded via d_req hold: force
//     stall_cnt to 16'hFFFF -> stays saturated; stall_clr pulse -> 0 next cycle.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//  Bus bundle between the three memory requesters, the shared single-port
//  memory and mem_port_arbiter.
//  Requester side : f_* (fetch, read only), d_* (data load/store),
//                   h_* (host/debug loader); req/addr/we/wdata in, gnt/rvalid out.
//  Memory side    : mem_en/mem_we/mem_addr/mem_wdata out, mem_rdata in.
//  rdata          : shared read-return bus, qualified by the x_rvalid strobes.
//  Modports: slave  = the arbiter,
//            master = requesters plus the memory (the arbiter's environment).
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int AW = 16,
   parameter int DW = 32
);
   // fetch port
   logic          f_req;
   logic [AW-1:0] f_addr;
   logic          f_gnt;
   logic          f_rvalid;
   // data port
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_gnt;
   logic          d_rvalid;
   // host loader port
   logic          h_req;
   logic          h_we;
   logic [AW-1:0] h_addr;
   logic [DW-1:0] h_wdata;
   logic          h_gnt;
   logic          h_rvalid;
   // shared read return
   logic [DW-1:0] rdata;
   // memory command / response
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  f_req, f_addr,
      input  d_req, d_we, d_addr, d_wdata,
      input  h_req, h_we, h_addr, h_wdata,
      input  mem_rdata,
      output f_gnt, f_rvalid, d_gnt, d_rvalid, h_gnt, h_rvalid,
      output rdata, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output f_req, f_addr,
      output d_req, d_we, d_addr, d_wdata,
      output h_req, h_we, h_addr, h_wdata,
      output mem_rdata,
      input  f_gnt, f_rvalid, d_gnt, d_rvalid, h_gnt, h_rvalid,
      input  rdata, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface : mem_port_arbiter_if

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//  Shares one single-port memory between instruction fetch (F), data
//  load/store (D) and the host loader (H). At most one access is granted per
//  cycle; grants are combinational, read data returns one cycle later on the
//  shared rdata bus with a per-port rvalid strobe.
//  H wins unless it has already taken HOST_BURST grants in a row while F/D
//  were waiting; F and D share round-robin. A saturating counter records
//  cycles in which fetch requested but was not granted.
// Ports
//  clk        : system clock, rising edge
//  reset      : asynchronous, active-low reset
//  bus        : mem_port_arbiter_if.slave (requesters + memory)
//  stall_clr  : synchronous clear of stall_cnt (wins over increment)
//  stall_cnt  : fetch stall cycles, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int AW         = 16,
   parameter int DW         = 32,
   parameter int HOST_BURST = 4    // 1..15
) (
   input  logic              clk,
   input  logic              reset,
   mem_port_arbiter_if.slave bus,
   input  logic              stall_clr,
   output logic [15:0]       stall_cnt
);

   typedef enum logic [1:0] {SEL_NONE, SEL_F, SEL_D, SEL_H} sel_e;

   localparam logic [3:0]  BURST     = 4'(HOST_BURST);
   localparam logic [15:0] STALL_MAX = 16'hFFFF;

   sel_e          sel;
   logic          fd_pend;
   logic          rr_last_q, rr_last_d;       // 1: D took the last F/D grant
   logic [3:0]    host_run_q, host_run_d;
   logic          f_rvalid_q, f_rvalid_d;
   logic          d_rvalid_q, d_rvalid_d;
   logic          h_rvalid_q, h_rvalid_d;
   logic [15:0]   stall_cnt_q, stall_cnt_d;
   logic          mem_we_c;
   logic [AW-1:0] mem_addr_c;
   logic [DW-1:0] mem_wdata_c;

   assign fd_pend = bus.f_req | bus.d_req;

   // -------------------------------------------------------------------------
   // Winner selection
   // -------------------------------------------------------------------------
   // NOTE: every always_comb output gets a default on entry so no path can
   // leave it unassigned and infer a latch.
   always_comb begin : arbitrate
      sel = SEL_NONE;
      // NOTE: grants are combinational, so they are gated by reset directly;
      // otherwise a held request would reach the memory while in reset.
      if (!reset) begin
         sel = SEL_NONE;
      end else if (bus.h_req && ((host_run_q < BURST) || !fd_pend)) begin
         sel = SEL_H;
      end else if (bus.f_req && bus.d_req) begin
         sel = rr_last_q ? SEL_F : SEL_D;
      end else if (bus.f_req) begin
         sel = SEL_F;
      end else if (bus.d_req) begin
         sel = SEL_D;
      end
   end

   // -------------------------------------------------------------------------
   // Memory command mux; idle cycles drive zeros
   // -------------------------------------------------------------------------
   always_comb begin : command_mux
      mem_we_c    = 1'b0;
      mem_addr_c  = '0;
      mem_wdata_c = '0;
      case (sel)
         SEL_F: begin
            mem_addr_c  = bus.f_addr;
         end
         SEL_D: begin
            mem_we_c    = bus.d_we;
            mem_addr_c  = bus.d_addr;
            mem_wdata_c = bus.d_wdata;
         end
         SEL_H: begin
            mem_we_c    = bus.h_we;
            mem_addr_c  = bus.h_addr;
            mem_wdata_c = bus.h_wdata;
         end
         default: ;
      endcase
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin : next_state
      rr_last_d   = rr_last_q;
      host_run_d  = host_run_q;
      stall_cnt_d = stall_cnt_q;

      // rvalid pipe: one cycle after a read grant
      f_rvalid_d = (sel == SEL_F);
      d_rvalid_d = (sel == SEL_D) && !bus.d_we;
      h_rvalid_d = (sel == SEL_H) && !bus.h_we;

      if (sel == SEL_F) begin
         rr_last_d = 1'b0;
      end else if (sel == SEL_D) begin
         rr_last_d = 1'b1;
      end

      // Host burst length only counts grants taken while F/D were waiting.
      // Reaching BURST blocks H until an F/D grant clears the run.
      if ((sel == SEL_H) && fd_pend) begin
         if (host_run_q != BURST) begin
            host_run_d = host_run_q + 4'd1;
         end
      end else if ((sel == SEL_F) || (sel == SEL_D) || !bus.h_req) begin
         host_run_d = '0;
      end

      if (stall_clr) begin
         stall_cnt_d = '0;
      end else if (bus.f_req && (sel != SEL_F) && (stall_cnt_q != STALL_MAX)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge reset) begin : state_reg
      if (!reset) begin
         rr_last_q   <= 1'b0;
         host_run_q  <= '0;
         f_rvalid_q  <= 1'b0;
         d_rvalid_q  <= 1'b0;
         h_rvalid_q  <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         rr_last_q   <= rr_last_d;
         host_run_q  <= host_run_d;
         f_rvalid_q  <= f_rvalid_d;
         d_rvalid_q  <= d_rvalid_d;
         h_rvalid_q  <= h_rvalid_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign bus.f_gnt     = (sel == SEL_F);
   assign bus.d_gnt     = (sel == SEL_D);
   assign bus.h_gnt     = (sel == SEL_H);
   assign bus.mem_en    = (sel != SEL_NONE);
   assign bus.mem_we    = mem_we_c;
   assign bus.mem_addr  = mem_addr_c;
   assign bus.mem_wdata = mem_wdata_c;
   assign bus.f_rvalid  = f_rvalid_q;
   assign bus.d_rvalid  = d_rvalid_q;
   assign bus.h_rvalid  = h_rvalid_q;
   assign bus.rdata     = bus.mem_rdata;
   assign stall_cnt     = stall_cnt_q;

endmodule : mem_port_arbiter
